// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer / control unit driving the 64-bit ALU
//
// Fetches 64-bit instruction words over a req/ack handshake, decodes them into
// ALU operands, and commits ALU results to a 16x64 register file, a two-entry
// flag history and the program counter.
//
// Ports:
//   clock, reset_n           clock (rising edge) and asynchronous active-low reset
//   imem_req/imem_addr       fetch request and word address (= PC)
//   imem_ack/imem_data       fetch response; data valid while ack=1
//   alu_instr..alu_F2        registered ALU inputs, updated only in DECODE
//   alu_C/F3/addrch/naddr    ALU results, captured at the end of EXEC
//   halted                   high once a halt or illegal opcode has committed

module alu_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [63:0] imem_data,
  output logic [5:0]  alu_instr,
  output logic [63:0] alu_A,
  output logic [63:0] alu_B,
  output logic [63:0] alu_reg8,
  output logic [31:0] alu_value,
  output logic        alu_highlow,
  output logic        alu_F1,
  output logic        alu_F2,
  input  logic [63:0] alu_C,
  input  logic        alu_F3,
  input  logic        alu_addrch,
  input  logic [63:0] alu_naddr,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        f1;
  logic        f2;
  logic [63:0] regs [16];

  // Latched instruction fields; bits [31:15] of the word carry nothing.
  logic [5:0]  ir_op;
  logic [3:0]  ir_rd;
  logic [3:0]  ir_rs;
  logic        ir_hl;
  logic [31:0] ir_val;

  // ALU results captured at the end of EXEC.
  logic [63:0] c_q;
  logic        f3_q;
  logic        addrch_q;
  logic [63:0] naddr_q;

  logic unused_ir_bits;
  assign unused_ir_bits = ^imem_data[31:15];

  // Commit decision for the instruction currently in WB.
  logic [63:0] pc_inc;
  logic [63:0] wb_pc;
  logic        wb_halt;
  logic        wb_reg_we;
  logic        wb_flag_we;
  logic [63:0] wb_reg_data;

  always_comb begin
    pc_inc      = pc + 64'd1;
    wb_pc       = pc_inc;
    wb_halt     = 1'b0;
    wb_reg_we   = 1'b0;
    wb_flag_we  = 1'b0;
    wb_reg_data = c_q;
    case (ir_op)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd16, 6'd17: begin
        wb_reg_we = 1'b1;
      end
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13: begin
        wb_flag_we = 1'b1;
      end
      6'd14, 6'd15: begin
        wb_pc = addrch_q ? naddr_q : pc_inc;
      end
      6'd6: begin
        // Jump-and-link: the link value is the fall-through address.
        wb_reg_we   = 1'b1;
        wb_reg_data = pc_inc;
        wb_pc       = naddr_q;
      end
      6'd7: begin
        wb_pc = naddr_q;
      end
      default: begin
        // Opcode 63 and every unassigned opcode stop the sequencer; PC holds.
        wb_halt = 1'b1;
        wb_pc   = pc;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      f1          <= 1'b0;
      f2          <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      ir_op       <= '0;
      ir_rd       <= '0;
      ir_rs       <= '0;
      ir_hl       <= 1'b0;
      ir_val      <= '0;
      c_q         <= '0;
      f3_q        <= 1'b0;
      addrch_q    <= 1'b0;
      naddr_q     <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      alu_instr   <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_reg8    <= '0;
      alu_value   <= '0;
      alu_highlow <= 1'b0;
      alu_F1      <= 1'b0;
      alu_F2      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // An ack only counts while the request is actually out.
          if (imem_req && imem_ack) begin
            ir_op    <= imem_data[5:0];
            ir_rd    <= imem_data[9:6];
            ir_rs    <= imem_data[13:10];
            ir_hl    <= imem_data[14];
            ir_val   <= imem_data[63:32];
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            // Raises the request on the first edge after reset release.
            imem_req <= 1'b1;
          end
        end

        S_DECODE: begin
          alu_instr   <= ir_op;
          alu_A       <= regs[ir_rd];
          alu_B       <= regs[ir_rs];
          alu_reg8    <= regs[8];
          alu_value   <= ir_val;
          alu_highlow <= ir_hl;
          alu_F1      <= f1;
          alu_F2      <= f2;
          state       <= S_EXEC;
        end

        S_EXEC: begin
          c_q      <= alu_C;
          f3_q     <= alu_F3;
          addrch_q <= alu_addrch;
          naddr_q  <= alu_naddr;
          state    <= S_WB;
        end

        S_WB: begin
          if (wb_reg_we) begin
            regs[ir_rd] <= wb_reg_data;
          end
          if (wb_flag_we) begin
            f2 <= f1;
            f1 <= f3_q;
          end
          pc        <= wb_pc;
          imem_addr <= wb_pc;
          if (wb_halt) begin
            halted   <= 1'b1;
            imem_req <= 1'b0;
            state    <= S_HALT;
          end else begin
            // Request goes out in the very next cycle for zero-wait fetch.
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_HALT: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
        end

        default: begin
          imem_req <= 1'b0;
          halted   <= 1'b1;
          state    <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU and architectural model

module tb_alu_sequencer;

  localparam logic [63:0] RPC = 64'h100;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack  = 1'b0;
  logic [63:0] imem_data = '0;
  logic [5:0]  alu_instr;
  logic [63:0] alu_A;
  logic [63:0] alu_B;
  logic [63:0] alu_reg8;
  logic [31:0] alu_value;
  logic        alu_highlow;
  logic        alu_F1;
  logic        alu_F2;
  logic [63:0] alu_C;
  logic        alu_F3;
  logic        alu_addrch;
  logic [63:0] alu_naddr;
  logic        halted;

  always #5 clock = ~clock;

  alu_sequencer #(.RESET_PC(RPC)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .alu_instr(alu_instr),
    .alu_A(alu_A),
    .alu_B(alu_B),
    .alu_reg8(alu_reg8),
    .alu_value(alu_value),
    .alu_highlow(alu_highlow),
    .alu_F1(alu_F1),
    .alu_F2(alu_F2),
    .alu_C(alu_C),
    .alu_F3(alu_F3),
    .alu_addrch(alu_addrch),
    .alu_naddr(alu_naddr),
    .halted(halted)
  );

  // Behavioural ALU on the far side of the sequencer.
  function automatic logic [63:0] f_c(input logic [5:0] op, input logic [63:0] a,
                                      input logic [63:0] b, input logic [31:0] v, input logic hl);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      6'd5:    return hl ? {v, a[31:0]} : {a[63:32], v};
      6'd16:   return a * b;
      6'd17:   return (b == 64'd0) ? '1 : a / b;
      default: return '0;
    endcase
  endfunction

  function automatic logic f_f3(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      6'd8:    return a == b;
      6'd9:    return a < b;
      6'd10:   return a > b;
      6'd11:   return a != b;
      6'd12:   return a <= b;
      6'd13:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_ch(input logic [5:0] op, input logic f1);
    case (op)
      6'd6, 6'd7: return 1'b1;
      6'd14:      return !f1;
      6'd15:      return f1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] f_na(input logic [5:0] op, input logic [63:0] r8);
    case (op)
      6'd6, 6'd7, 6'd14, 6'd15: return r8;
      default:                  return '0;
    endcase
  endfunction

  assign alu_C      = f_c(alu_instr, alu_A, alu_B, alu_value, alu_highlow);
  assign alu_F3     = f_f3(alu_instr, alu_A, alu_B);
  assign alu_addrch = f_ch(alu_instr, alu_F1);
  assign alu_naddr  = f_na(alu_instr, alu_reg8);

  function automatic logic [63:0] enc(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                      input logic hl, input logic [31:0] v);
    return {v, 17'h15A5A, hl, rs, rd, op};
  endfunction

  // Architectural model.
  logic [63:0] m_r [16];
  logic [63:0] m_pc;
  logic        m_f1;
  logic        m_f2;
  logic        m_halt;

  // Expected DUT outputs, maintained by the stimulus process.
  logic        e_req;
  logic [63:0] e_addr;
  logic [5:0]  e_instr;
  logic [63:0] e_A;
  logic [63:0] e_B;
  logic [63:0] e_r8;
  logic [31:0] e_val;
  logic        e_hl;
  logic        e_f1;
  logic        e_f2;
  logic        e_halted;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("imem_req",    64'(imem_req),    64'(e_req));
      chk("imem_addr",   imem_addr,        e_addr);
      chk("alu_instr",   64'(alu_instr),   64'(e_instr));
      chk("alu_A",       alu_A,            e_A);
      chk("alu_B",       alu_B,            e_B);
      chk("alu_reg8",    alu_reg8,         e_r8);
      chk("alu_value",   64'(alu_value),   64'(e_val));
      chk("alu_highlow", 64'(alu_highlow), 64'(e_hl));
      chk("alu_F1",      64'(alu_F1),      64'(e_f1));
      chk("alu_F2",      64'(alu_F2),      64'(e_f2));
      chk("halted",      64'(halted),      64'(e_halted));
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = RPC; m_f1 = 1'b0; m_f2 = 1'b0; m_halt = 1'b0;
    e_req = 1'b0; e_addr = RPC; e_instr = '0; e_A = '0; e_B = '0; e_r8 = '0;
    e_val = '0; e_hl = 1'b0; e_f1 = 1'b0; e_f2 = 1'b0; e_halted = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_async_req", 64'(imem_req), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    e_req = 1'b1;
    chk("rst_addr_lit", imem_addr, 64'h100);
  endtask

  // Fetches one word (after 'waits' ack-low cycles) and follows it to commit;
  // with 'abort' set, reset is asserted during EXEC instead.
  task automatic run_instr(input logic [63:0] w, input int waits, input bit abort);
    int          n;
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        hl;
    logic [31:0] v;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r8;
    logic [63:0] c;
    logic        f3;
    logic        ch;
    logic [63:0] na;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    chk("fetch_req", 64'(imem_req), 64'd1);
    chk("fetch_addr", imem_addr, m_pc);
    repeat (waits) begin
      @(posedge clock); #1;
    end
    imem_data = w;
    imem_ack  = 1'b1;
    @(posedge clock); #1;
    imem_ack  = 1'b0;
    imem_data = {$urandom, $urandom};
    e_req     = 1'b0;
    op = w[5:0]; rd = w[9:6]; rs = w[13:10]; hl = w[14]; v = w[63:32];
    a = m_r[rd]; b = m_r[rs]; r8 = m_r[8];
    @(posedge clock); #1;
    e_instr = op; e_A = a; e_B = b; e_r8 = r8; e_val = v; e_hl = hl; e_f1 = m_f1; e_f2 = m_f2;
    if (abort) begin
      do_reset();
      return;
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    c = f_c(op, a, b, v, hl); f3 = f_f3(op, a, b); ch = f_ch(op, m_f1); na = f_na(op, r8);
    if (op inside {[6'd0:6'd5], 6'd16, 6'd17}) begin
      m_r[rd] = c; m_pc = m_pc + 64'd1;
    end else if (op inside {[6'd8:6'd13]}) begin
      m_f2 = m_f1; m_f1 = f3; m_pc = m_pc + 64'd1;
    end else if (op == 6'd14 || op == 6'd15) begin
      m_pc = ch ? na : m_pc + 64'd1;
    end else if (op == 6'd6) begin
      m_r[rd] = m_pc + 64'd1; m_pc = na;
    end else if (op == 6'd7) begin
      m_pc = na;
    end else begin
      m_halt = 1'b1;
    end
    e_req = !m_halt; e_addr = m_pc; e_halted = m_halt;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_ack = ~imem_ack;
      @(posedge clock); #1;
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    run_instr(enc(6'd5, 4'd1, 4'd0, 1'b0, 32'h12345678), 0, 1'b0);
    run_instr(enc(6'd0, 4'd1, 4'd1, 1'b0, 32'h0), 0, 1'b0);
    run_instr(enc(6'd3, 4'd1, 4'd1, 1'b0, 32'h0), 0, 1'b0);
    chk("add_result_lit", alu_A, 64'h2468ACF0);

    run_instr(enc(6'd5, 4'd2, 4'd0, 1'b0, 32'd7), 0, 1'b0);
    run_instr(enc(6'd5, 4'd3, 4'd0, 1'b0, 32'd7), 0, 1'b0);
    run_instr(enc(6'd5, 4'd8, 4'd0, 1'b0, 32'h40), 0, 1'b0);
    run_instr(enc(6'd8, 4'd2, 4'd3, 1'b0, 32'h0), 0, 1'b0);
    run_instr(enc(6'd15, 4'd0, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    chk("br_taken_lit", imem_addr, 64'h40);
    chk("br_f1_lit", 64'(alu_F1), 64'd1);

    run_instr(enc(6'd5, 4'd3, 4'd0, 1'b0, 32'd8), 0, 1'b0);
    run_instr(enc(6'd8, 4'd2, 4'd3, 1'b0, 32'h0), 0, 1'b0);
    run_instr(enc(6'd15, 4'd0, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    chk("br_not_taken_lit", imem_addr, 64'h43);
    chk("flag_hist_f1_lit", 64'(alu_F1), 64'd0);
    chk("flag_hist_f2_lit", 64'(alu_F2), 64'd1);

    run_instr(enc(6'd5, 4'd8, 4'd0, 1'b0, 32'hF), 0, 1'b0);
    run_instr(enc(6'd7, 4'd0, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    chk("jump_lit", imem_addr, 64'hF);
    run_instr(enc(6'd5, 4'd8, 4'd0, 1'b0, 32'h80), 0, 1'b0);
    run_instr(enc(6'd6, 4'd4, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    chk("jal_target_lit", imem_addr, 64'h80);
    run_instr(enc(6'd0, 4'd4, 4'd4, 1'b0, 32'h0), 5, 1'b0);
    chk("jal_link_lit", alu_A, 64'h11);

    run_instr(enc(6'd17, 4'd5, 4'd6, 1'b0, 32'h0), 0, 1'b0);
    run_instr(enc(6'd16, 4'd5, 4'd4, 1'b0, 32'h0), 2, 1'b0);
    run_instr(enc(6'd14, 4'd0, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    run_instr(enc(6'd9, 4'd4, 4'd2, 1'b0, 32'h0), 1, 1'b0);

    run_instr(enc(6'd5, 4'd8, 4'd0, 1'b0, 32'hFFFFFFFF), 0, 1'b0);
    run_instr(enc(6'd5, 4'd8, 4'd0, 1'b1, 32'hFFFFFFFF), 0, 1'b0);
    run_instr(enc(6'd7, 4'd0, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    chk("jump_max_lit", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    run_instr(enc(6'd4, 4'd0, 4'd1, 1'b0, 32'h0), 2, 1'b0);
    chk("pc_wrap_lit", imem_addr, 64'h0);

    run_instr(enc(6'd63, 4'd0, 4'd0, 1'b0, 32'h0), 0, 1'b0);
    chk("halt_lit", 64'(halted), 64'd1);
    idle(10);

    do_reset();
    run_instr(enc(6'h2A, 4'd1, 4'd1, 1'b0, 32'h0), 0, 1'b0);
    chk("illegal_halt_lit", 64'(halted), 64'd1);
    idle(10);

    do_reset();
    run_instr(enc(6'd5, 4'd1, 4'd0, 1'b0, 32'h55), 0, 1'b0);
    run_instr(enc(6'd0, 4'd1, 4'd1, 1'b0, 32'h0), 0, 1'b1);
    run_instr(enc(6'd0, 4'd1, 4'd1, 1'b0, 32'h0), 0, 1'b0);
    chk("abort_rd_lit", alu_A, 64'h0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
